// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    localparam logic [4:0] REG_ZERO   = 5'd0;
    localparam int         WAIT_CNT_W = 8;

endpackage

// File: rtl/haz_wait_timer.sv
// Memory wait-state timer: counts MEM_WAIT cycles and flags when the count
// reaches MEM_TIMEOUT. The counter never wraps because the FSM aborts the
// wait on expiry.
import hazard_pkg::*;

module haz_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_V = WAIT_CNT_W'(MEM_TIMEOUT);

    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Load 1 on entry to the wait, clear on exit, otherwise count held cycles.
    always_ff @(posedge clk) begin
        if (rst)
            wait_cnt <= '0;
        else if (start)
            wait_cnt <= WAIT_CNT_W'(1);
        else if (clear)
            wait_cnt <= '0;
        else if (inc)
            wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
    end

    assign expired = (wait_cnt == TIMEOUT_V);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// MEM-stage redirects and data-memory wait states with timeout.
// Optional build macro: HAZ_PERF_CNT_EN adds stall_cycles / flush_count
// saturating performance counters.
import hazard_pkg::*;

module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ID_EX_MemRead,
    input  logic [4:0] ID_EX_RegisterRt,
    input  logic [4:0] IF_ID_RegisterRs,
    input  logic [4:0] IF_ID_RegisterRt,
    input  logic       EX_MEM_Branch,
    input  logic       EX_MEM_ALU_zero,
    input  logic       EX_MEM_Jump,
    input  logic       EX_MEM_MemAccess,
    input  logic       dmem_ready,
    output logic       PC_Write,
    output logic       IF_ID_Write,
    output logic       Pipe_Hold,
    output logic       PC_Redirect,
    output logic       IF_Flush,
    output logic       ID_Flush,
    output logic       EX_Flush,
    output logic       mem_timeout_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
`endif
);

    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255 || CNT_W < 1) begin : g_param_check
        $error("pipeline_hazard_ctrl: MEM_TIMEOUT must be 1..255 and CNT_W >= 1");
    end

    state_t state, state_nxt;
    logic   redir_pend, pend_nxt;
    logic   taken, lu, mem_stall;
    logic   tmr_start, tmr_clear, tmr_inc, tmr_expired, set_err;

    assign taken     = EX_MEM_Jump | (EX_MEM_Branch & EX_MEM_ALU_zero);
    assign lu        = ID_EX_MemRead && (ID_EX_RegisterRt != REG_ZERO) &&
                       ((ID_EX_RegisterRt == IF_ID_RegisterRs) ||
                        (ID_EX_RegisterRt == IF_ID_RegisterRt));
    assign mem_stall = EX_MEM_MemAccess & ~dmem_ready;

    haz_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (tmr_start),
        .clear   (tmr_clear),
        .inc     (tmr_inc),
        .expired (tmr_expired)
    );

    // State, pending-redirect and sticky timeout flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= RUN;
            redir_pend      <= 1'b0;
            mem_timeout_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            redir_pend <= pend_nxt;
            if (set_err)
                mem_timeout_err <= 1'b1;
        end
    end

    // Next-state and pipeline control decode; mem wait beats redirect beats load-use.
    always_comb begin
        PC_Write    = 1'b1;
        IF_ID_Write = 1'b1;
        Pipe_Hold   = 1'b0;
        PC_Redirect = 1'b0;
        IF_Flush    = 1'b0;
        ID_Flush    = 1'b0;
        EX_Flush    = 1'b0;
        state_nxt   = state;
        pend_nxt    = redir_pend;
        tmr_start   = 1'b0;
        tmr_clear   = 1'b0;
        tmr_inc     = 1'b0;
        set_err     = 1'b0;
        if (rst) begin
            PC_Write    = 1'b0;
            IF_ID_Write = 1'b0;
            IF_Flush    = 1'b1;
            ID_Flush    = 1'b1;
            EX_Flush    = 1'b1;
            state_nxt   = RUN;
            pend_nxt    = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_stall) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        Pipe_Hold   = 1'b1;
                        pend_nxt    = taken;
                        tmr_start   = 1'b1;
                        state_nxt   = MEM_WAIT;
                    end else if (taken) begin
                        // Redirect squashes IF, ID and EX; a load-use victim dies with them.
                        PC_Redirect = 1'b1;
                        IF_Flush    = 1'b1;
                        ID_Flush    = 1'b1;
                        EX_Flush    = 1'b1;
                    end else if (lu) begin
                        PC_Write    = 1'b0;
                        IF_ID_Write = 1'b0;
                        ID_Flush    = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    PC_Write    = 1'b0;
                    IF_ID_Write = 1'b0;
                    Pipe_Hold   = 1'b1;
                    if (dmem_ready || tmr_expired) begin
                        set_err   = ~dmem_ready;
                        tmr_clear = 1'b1;
                        state_nxt = redir_pend ? REDIRECT : RUN;
                    end else begin
                        tmr_inc = 1'b1;
                    end
                end
                REDIRECT: begin
                    PC_Redirect = 1'b1;
                    IF_Flush    = 1'b1;
                    ID_Flush    = 1'b1;
                    EX_Flush    = 1'b1;
                    pend_nxt    = 1'b0;
                    state_nxt   = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating counts of stalled-fetch cycles and EX flush cycles outside reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (!PC_Write)
                stall_cycles <= sat_inc(stall_cycles);
            if (EX_Flush)
                flush_count <= sat_inc(flush_count);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
// Control outputs are compared as one vector:
// {PC_Write, IF_ID_Write, Pipe_Hold, PC_Redirect, IF_Flush, ID_Flush, EX_Flush}
module tb_pipeline_hazard_ctrl;

    localparam logic [6:0] O_NORM  = 7'b1100000;
    localparam logic [6:0] O_RST   = 7'b0000111;
    localparam logic [6:0] O_LU    = 7'b0000010;
    localparam logic [6:0] O_REDIR = 7'b1101111;
    localparam logic [6:0] O_HOLD  = 7'b0010000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ID_EX_MemRead;
    logic [4:0] ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt;
    logic       EX_MEM_Branch, EX_MEM_ALU_zero, EX_MEM_Jump, EX_MEM_MemAccess, dmem_ready;
    logic       PC_Write, IF_ID_Write, Pipe_Hold, PC_Redirect;
    logic       IF_Flush, ID_Flush, EX_Flush, mem_timeout_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif
    logic [6:0] outs;

    int total = 0;
    int bad   = 0;

    assign outs = {PC_Write, IF_ID_Write, Pipe_Hold, PC_Redirect, IF_Flush, ID_Flush, EX_Flush};

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .ID_EX_MemRead    (ID_EX_MemRead),
        .ID_EX_RegisterRt (ID_EX_RegisterRt),
        .IF_ID_RegisterRs (IF_ID_RegisterRs),
        .IF_ID_RegisterRt (IF_ID_RegisterRt),
        .EX_MEM_Branch    (EX_MEM_Branch),
        .EX_MEM_ALU_zero  (EX_MEM_ALU_zero),
        .EX_MEM_Jump      (EX_MEM_Jump),
        .EX_MEM_MemAccess (EX_MEM_MemAccess),
        .dmem_ready       (dmem_ready),
        .PC_Write         (PC_Write),
        .IF_ID_Write      (IF_ID_Write),
        .Pipe_Hold        (Pipe_Hold),
        .PC_Redirect      (PC_Redirect),
        .IF_Flush         (IF_Flush),
        .ID_Flush         (ID_Flush),
        .EX_Flush         (EX_Flush),
        .mem_timeout_err  (mem_timeout_err)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cycles     (stall_cycles),
        .flush_count      (flush_count)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ID_EX_MemRead = 0; ID_EX_RegisterRt = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
        EX_MEM_Branch = 0; EX_MEM_ALU_zero = 0; EX_MEM_Jump = 0;
        EX_MEM_MemAccess = 0; dmem_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; idle_inputs();
        tick(); tick();
        #2;
        total++; if (outs !== O_RST) begin bad++; $display("FAIL reset_outs got=%b want=%b", outs, O_RST); end
        total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", mem_timeout_err); end
`ifdef HAZ_PERF_CNT_EN
        total++; if (stall_cycles !== 0 || flush_count !== 0) begin bad++; $display("FAIL reset_perf got=%0d/%0d want=0/0", stall_cycles, flush_count); end
`endif
        tick();
        rst = 0;
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL post_reset got=%b want=%b", outs, O_NORM); end
        tick();
    endtask

    task automatic test_load_use();
        // lw Rt=5 in EX, ID reads Rs=5
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 5; IF_ID_RegisterRs = 5; IF_ID_RegisterRt = 7;
        #2;
        total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rs got=%b want=%b", outs, O_LU); end
        tick();
        ID_EX_MemRead = 0; ID_EX_RegisterRt = 0;
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL lu_after got=%b want=%b", outs, O_NORM); end
        tick();
        // match on the ID instruction's Rt
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 9; IF_ID_RegisterRs = 3; IF_ID_RegisterRt = 9;
        #2;
        total++; if (outs !== O_LU) begin bad++; $display("FAIL lu_rt got=%b want=%b", outs, O_LU); end
        tick();
        // register match but no load
        ID_EX_MemRead = 0;
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL lu_noload got=%b want=%b", outs, O_NORM); end
        tick();
        // load to $zero never stalls
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 0; IF_ID_RegisterRs = 0; IF_ID_RegisterRt = 0;
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL lu_zero got=%b want=%b", outs, O_NORM); end
        tick();
        idle_inputs();
    endtask

    task automatic test_redirect();
        // jump with a load-use present: redirect wins, no stall
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 6; IF_ID_RegisterRs = 6; EX_MEM_Jump = 1;
        #2;
        total++; if (outs !== O_REDIR) begin bad++; $display("FAIL jump_lu got=%b want=%b", outs, O_REDIR); end
        tick();
        idle_inputs();
        EX_MEM_Branch = 1; EX_MEM_ALU_zero = 1;
        #2;
        total++; if (outs !== O_REDIR) begin bad++; $display("FAIL br_taken got=%b want=%b", outs, O_REDIR); end
        tick();
        EX_MEM_ALU_zero = 0;
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL br_not_taken got=%b want=%b", outs, O_NORM); end
        tick();
        idle_inputs();
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL after_redirect got=%b want=%b", outs, O_NORM); end
        tick();
    endtask

    task automatic test_mem_wait();
        // memory ready at once: no stall
        EX_MEM_MemAccess = 1; dmem_ready = 1;
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL mem_ready_now got=%b want=%b", outs, O_NORM); end
        tick();
        // 3 cycles not ready with a taken branch and a load-use; memory has priority
        dmem_ready = 0; EX_MEM_Branch = 1; EX_MEM_ALU_zero = 1;
        ID_EX_MemRead = 1; ID_EX_RegisterRt = 4; IF_ID_RegisterRs = 4;
        for (int i = 0; i < 3; i++) begin
            #2;
            total++; if (outs !== O_HOLD) begin bad++; $display("FAIL mem_hold%0d got=%b want=%b", i, outs, O_HOLD); end
            tick();
        end
        dmem_ready = 1;
        #2;
        total++; if (outs !== O_HOLD) begin bad++; $display("FAIL mem_ready_cycle got=%b want=%b", outs, O_HOLD); end
        tick();
        idle_inputs();
        #2;
        total++; if (outs !== O_REDIR) begin bad++; $display("FAIL pend_redirect got=%b want=%b", outs, O_REDIR); end
        tick();
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL after_pend got=%b want=%b", outs, O_NORM); end
        tick();
        // wait without a redirect: no pulse afterwards
        EX_MEM_MemAccess = 1; dmem_ready = 0;
        #2;
        total++; if (outs !== O_HOLD) begin bad++; $display("FAIL mem2_hold got=%b want=%b", outs, O_HOLD); end
        tick();
        dmem_ready = 1;
        #2;
        total++; if (outs !== O_HOLD) begin bad++; $display("FAIL mem2_ready got=%b want=%b", outs, O_HOLD); end
        tick();
        idle_inputs();
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL mem2_no_pulse got=%b want=%b", outs, O_NORM); end
        total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL mem_err_clear got=%b want=0", mem_timeout_err); end
        tick();
    endtask

    task automatic test_timeout();
        // entry cycle in RUN plus MEM_WAIT with wait_cnt=1..4
        EX_MEM_MemAccess = 1; dmem_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #2;
            total++; if (outs !== O_HOLD) begin bad++; $display("FAIL to_hold%0d got=%b want=%b", i, outs, O_HOLD); end
            total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL to_err_early%0d got=%b want=0", i, mem_timeout_err); end
            tick();
        end
        EX_MEM_MemAccess = 0;
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL to_back_run got=%b want=%b", outs, O_NORM); end
        total++; if (mem_timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_set got=%b want=1", mem_timeout_err); end
        tick(); tick(); tick();
        #2;
        total++; if (mem_timeout_err !== 1'b1) begin bad++; $display("FAIL to_err_sticky got=%b want=1", mem_timeout_err); end
        tick();
    endtask

    task automatic test_reset_in_wait();
        EX_MEM_MemAccess = 1; dmem_ready = 0; EX_MEM_Jump = 1;
        tick();
        #2;
        total++; if (outs !== O_HOLD) begin bad++; $display("FAIL rw_hold got=%b want=%b", outs, O_HOLD); end
        rst = 1;
        #1;
        total++; if (outs !== O_RST) begin bad++; $display("FAIL rw_rst_outs got=%b want=%b", outs, O_RST); end
        tick();
        rst = 0; idle_inputs();
        #2;
        total++; if (outs !== O_NORM) begin bad++; $display("FAIL rw_no_pulse got=%b want=%b", outs, O_NORM); end
        total++; if (mem_timeout_err !== 1'b0) begin bad++; $display("FAIL rw_err_cleared got=%b want=0", mem_timeout_err); end
`ifdef HAZ_PERF_CNT_EN
        total++; if (stall_cycles !== 0 || flush_count !== 0) begin bad++; $display("FAIL rw_perf got=%0d/%0d want=0/0", stall_cycles, flush_count); end
`endif
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_mem_wait();
        test_timeout();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
